// File: rtl/prog_loader.sv
// prog_loader - serial program loader (writer side of the CPU program RAM).
//
// Receives an 8N1-style UART stream (n data bits, LSB first) and writes a
// framed program image into RAM starting at address 0, holding the CPU in
// reset for the duration of the load.
//
// Frame: 0xA5 sync, COUNT (0 = 2**n bytes), COUNT data bytes, CSUM, where
// CSUM = sum of the data bytes mod 2**n.
//
// Parameters:
//   n             data and address width (RAM depth 2**n)
//   CLKS_PER_BIT  clocks per UART bit; must be even and >= 4
//   TIMEOUT_BITS  idle bit-times between bytes before abort (timeout build only)
//
// Ports:
//   Clock    in   system clock, all logic on the rising edge
//   Reset    in   asynchronous active-low reset
//   RxD      in   UART receive line (asynchronous, idles high)
//   LoadReq  in   level; high while running requests a load
//   WrEn     out  one-cycle RAM write strobe
//   WrAddr   out  RAM write address
//   WrData   out  RAM write data
//   CpuHold  out  1 = hold the CPU in reset
//   Busy     out  1 = loader is in any state other than RUN
//   Done     out  one-cycle pulse on a successful load
//   Error    out  sticky framing / checksum / timeout error
//
// Configuration macro:
//   PROG_LOADER_TIMEOUT_EN  when defined, an idle line gap of at least
//                           TIMEOUT_BITS*CLKS_PER_BIT clocks while in COUNT,
//                           DATA or CSUM aborts the load (Error=1, back to SYNC).
//                           When undefined a stalled frame waits forever.

module prog_loader #(
  parameter int n            = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         RxD,
  input  logic         LoadReq,
  output logic         WrEn,
  output logic [n-1:0] WrAddr,
  output logic [n-1:0] WrData,
  output logic         CpuHold,
  output logic         Busy,
  output logic         Done,
  output logic         Error
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = (n > 1) ? $clog2(n) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(n - 1);
  localparam logic [n-1:0]  SYNC_BYTE = n'(8'hA5);

  generate
    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || TIMEOUT_BITS < 1 || n < 2) begin : g_bad_params
      $error("prog_loader: illegal parameter value");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     rx_state;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] bit_cnt;
  logic [IW-1:0] bit_idx;
  logic [n-1:0]  rx_shift;
  logic          rx_strobe;   // one cycle: rx_shift holds a good byte
  logic          rx_ferr;     // one cycle: stop bit sampled low

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= R_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      rx_strobe <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_s1     <= RxD;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rx_strobe <= 1'b0;
      rx_ferr   <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= R_START;
            bit_cnt  <= '0;
          end
        end
        R_START: begin
          // Re-check the line half a bit in; a glitch shorter than that is dropped.
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            rx_state <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            rx_shift <= {rx_s2, rx_shift[n-1:1]};
            if (bit_idx == IDX_LAST) rx_state <= R_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            rx_state <= R_IDLE;
            if (rx_s2) rx_strobe <= 1'b1;
            else       rx_ferr   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {S_RUN, S_SYNC, S_COUNT, S_DATA, S_CSUM} state_t;

  state_t       state;
  logic [n:0]   remaining;   // one extra bit so COUNT=0 can mean 2**n
  logic [n-1:0] sum;
  logic         timeout;

`ifdef PROG_LOADER_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  logic [TW-1:0] idle_cnt;
  logic          timed;

  assign timed   = (state == S_COUNT) || (state == S_DATA) || (state == S_CSUM);
  assign timeout = timed && (idle_cnt == TW'(TO_LIMIT));

  // Only line-idle time counts: a byte in flight or a strobe restarts it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      idle_cnt <= '0;
    end else if (!timed || rx_strobe || rx_state != R_IDLE) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TW'(TO_LIMIT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_RUN;
      remaining <= '0;
      sum       <= '0;
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      WrData    <= '0;
      CpuHold   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      WrEn <= 1'b0;
      Done <= 1'b0;
      // Address advances the cycle after each write; wraps naturally at 2**n.
      if (WrEn) WrAddr <= WrAddr + 1'b1;

      case (state)
        S_RUN: begin
          if (LoadReq) begin
            state   <= S_SYNC;
            CpuHold <= 1'b1;
            Busy    <= 1'b1;
          end
        end
        S_SYNC: begin
          if (rx_strobe && rx_shift == SYNC_BYTE) begin
            state <= S_COUNT;
            Error <= 1'b0;
          end
        end
        S_COUNT: begin
          if (rx_strobe) begin
            remaining <= (rx_shift == '0) ? {1'b1, {n{1'b0}}} : {1'b0, rx_shift};
            WrAddr    <= '0;
            sum       <= '0;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_strobe) begin
            WrData    <= rx_shift;
            WrEn      <= 1'b1;
            sum       <= sum + rx_shift;
            remaining <= remaining - 1'b1;
            if (remaining == (n+1)'(1)) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_strobe) begin
            if (rx_shift == sum) begin
              Done    <= 1'b1;
              state   <= S_RUN;
              CpuHold <= 1'b0;
              Busy    <= 1'b0;
            end else begin
              Error <= 1'b1;
              state <= S_SYNC;
            end
          end
        end
        default: state <= S_SYNC;
      endcase

      // Line errors only matter while loading; in RUN the CPU owns the
      // system and stray serial traffic is simply dropped.
      if (state != S_RUN && (rx_ferr || timeout)) begin
        Error <= 1'b1;
        state <= S_SYNC;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed UART frames, scoreboard of expected
// RAM writes / Done pulses / Error rises checked by an independent monitor.
module tb_prog_loader;

  localparam int N   = 8;
  localparam int CPB = 4;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         RxD = 1'b1;
  logic         LoadReq = 1'b0;
  logic         WrEn;
  logic [N-1:0] WrAddr;
  logic [N-1:0] WrData;
  logic         CpuHold;
  logic         Busy;
  logic         Done;
  logic         Error;

  prog_loader #(.n(N), .CLKS_PER_BIT(CPB), .TIMEOUT_BITS(4)) dut (
    .Clock(Clock), .Reset(Reset), .RxD(RxD), .LoadReq(LoadReq),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .CpuHold(CpuHold), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  // kind: 0 = write, 1 = done pulse, 2 = error rise
  typedef struct {
    int kind;
    int addr;
    int data;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  logic err_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int addr, input int data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic observe(input int kind, input int addr, input int data);
    exp_t e;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual kind=%0d addr=%0h data=%0h required none", kind, addr, data);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.addr != addr || e.data != data) begin
        failures++;
        $display("FAIL event actual kind=%0d addr=%0h data=%0h required kind=%0d addr=%0h data=%0h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end else if (kind == 0) begin
        if (addr < 4 || addr > 252) $display("write addr=%02h data=%02h ok", addr, data);
      end else begin
        $display("event kind=%0d ok", kind);
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge Clock) begin
    if (!Reset) begin
      err_prev <= 1'b0;
    end else begin
      if (WrEn) observe(0, int'(WrAddr), int'(WrData));
      if (Done) observe(1, 0, 0);
      if (Error && !err_prev) observe(2, 0, 0);
      err_prev <= Error;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RxD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      tick(CPB);
    end
    RxD = stop;
    tick(CPB);
    RxD = 1'b1;
    tick(CPB);
  endtask

  task automatic start_load(input string name);
    int waited;
    waited = 0;
    LoadReq = 1'b1;
    while (!Busy && waited < 10) begin
      tick(1);
      waited++;
    end
    LoadReq = 1'b0;
    chk({name, "_busy"}, Busy, 1'b1);
    chk({name, "_cpuhold"}, CpuHold, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    chk("rst_wren", WrEn, 1'b0);
    chk("rst_wraddr", WrAddr, 8'h00);
    chk("rst_wrdata", WrData, 8'h00);
    chk("rst_cpuhold", CpuHold, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_error", Error, 1'b0);
    Reset = 1'b1;
    tick(3);

    // Good 3-byte load
    start_load("t1");
    push(0, 0, 8'h11); push(0, 1, 8'h22); push(0, 2, 8'h33); push(1, 0, 0);
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
    send_byte(8'h66, 1'b1);
    tick(4);
    chk("t1_queue_empty", expq.size(), 0);
    chk("t1_cpuhold", CpuHold, 1'b0);
    chk("t1_busy", Busy, 1'b0);
    chk("t1_error", Error, 1'b0);

    // Checksum mismatch, then recovery
    start_load("t2");
    push(0, 0, 8'h10); push(0, 1, 8'h20); push(2, 0, 0);
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h10, 1'b1); send_byte(8'h20, 1'b1); send_byte(8'h00, 1'b1);
    tick(2);
    chk("t2_error", Error, 1'b1);
    chk("t2_busy", Busy, 1'b1);
    chk("t2_queue_empty", expq.size(), 0);
    send_byte(8'hA5, 1'b1);
    chk("t2_error_cleared", Error, 1'b0);
    push(0, 0, 8'h07); push(1, 0, 0);
    send_byte(8'h01, 1'b1); send_byte(8'h07, 1'b1); send_byte(8'h07, 1'b1);
    tick(2);
    chk("t2b_queue_empty", expq.size(), 0);
    chk("t2b_busy", Busy, 1'b0);

    // Framing error during DATA
    start_load("t3");
    push(0, 0, 8'h11); push(2, 0, 0);
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b0);
    tick(2);
    chk("t3_error", Error, 1'b1);
    chk("t3_busy", Busy, 1'b1);
    chk("t3_queue_empty", expq.size(), 0);
    push(0, 0, 8'h05); push(1, 0, 0);
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h05, 1'b1); send_byte(8'h05, 1'b1);
    tick(2);
    chk("t3b_queue_empty", expq.size(), 0);
    chk("t3b_error", Error, 1'b0);

    // 256-byte load with address wrap
    start_load("t4");
    for (int a = 0; a < 256; a++) push(0, a, 8'h01);
    push(1, 0, 0);
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1);
    for (int a = 0; a < 256; a++) send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(2);
    chk("t4_queue_empty", expq.size(), 0);
    chk("t4_wraddr_wrapped", WrAddr, 8'h00);
    chk("t4_busy", Busy, 1'b0);

    // Stalled frame
    start_load("t5");
    push(0, 0, 8'h55);
`ifdef PROG_LOADER_TIMEOUT_EN
    push(2, 0, 0);
`endif
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h55, 1'b1);
    tick(16 * CPB);
`ifdef PROG_LOADER_TIMEOUT_EN
    chk("t5_error", Error, 1'b1);
`else
    chk("t5_error", Error, 1'b0);
`endif
    chk("t5_busy", Busy, 1'b1);
    chk("t5_queue_empty", expq.size(), 0);

    // Reset mid-load
    Reset = 1'b0;
    tick(2);
    chk("rst2_busy", Busy, 1'b0);
    chk("rst2_cpuhold", CpuHold, 1'b0);
    chk("rst2_wraddr", WrAddr, 8'h00);
    chk("rst2_error", Error, 1'b0);
    Reset = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
